// File: rtl/bitcoin_nonce_select.sv
// Collects 16 per-nonce final H0 words, tracks the smallest one and writes them all to memory.
// Latency: mask-completing transfer to done=1 is 17 cycles (18 with BITCOIN_NONCE_SELECT_BEST_WORD_EN).
// Backpressure: in_ready is high only while collecting; results offered outside COLLECT are not taken.
//
// Optional feature macro: BITCOIN_NONCE_SELECT_BEST_WORD_EN appends {27'b0, found, best_nonce}
// as a 17th word at output_addr+16.
//
// Ports:
//   clk, reset_n                 - clock, async active-low reset
//   start, output_addr, target   - run kick-off; address base and threshold latched on accept
//   in_valid/in_nonce/in_hash    - result stream from the hash pipes; in_ready accepts
//   done, found, best_nonce,
//   best_hash, dup_err           - run status; hold in IDLE until the next accepted start
//   mem_clk, mem_we, mem_addr,
//   mem_write_data               - registered write port to result memory
module bitcoin_nonce_select (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] output_addr,
  input  logic [31:0] target,
  input  logic        in_valid,
  input  logic [3:0]  in_nonce,
  input  logic [31:0] in_hash,
  output logic        in_ready,
  output logic        done,
  output logic        found,
  output logic [3:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic        dup_err,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  // The write counter steps once per WRITE cycle; the final count value is the
  // cycle that drops mem_we and returns to IDLE.
`ifdef BITCOIN_NONCE_SELECT_BEST_WORD_EN
  localparam logic [4:0] LAST_CNT = 5'd17;
`else
  localparam logic [4:0] LAST_CNT = 5'd16;
`endif

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] target_q, target_d;
  logic [15:0] seen_q, seen_d;
  logic        dup_q, dup_d;
  logic [31:0] best_hash_q, best_hash_d;
  logic [3:0]  best_nonce_q, best_nonce_d;
  logic        found_q, found_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        buf_we;
  logic [31:0] buf_q [16];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    target_d     = target_q;
    seen_d       = seen_q;
    dup_d        = dup_q;
    best_hash_d  = best_hash_q;
    best_nonce_d = best_nonce_q;
    found_d      = found_q;
    wcnt_d       = wcnt_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    buf_we       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d       = output_addr;
          target_d     = target;
          seen_d       = '0;
          dup_d        = 1'b0;
          best_hash_d  = 32'hFFFF_FFFF;
          best_nonce_d = 4'd0;
          wcnt_d       = 5'd0;
          state_d      = S_COLLECT;
        end
      end

      S_COLLECT: begin
        if (in_valid) begin
          if (seen_q[in_nonce]) begin
            dup_d = 1'b1;
          end else begin
            seen_d[in_nonce] = 1'b1;
            buf_we           = 1'b1;
            // Ties on hash go to the lower nonce so the result is order independent.
            if ((in_hash < best_hash_q) ||
                ((in_hash == best_hash_q) && (in_nonce < best_nonce_q))) begin
              best_hash_d  = in_hash;
              best_nonce_d = in_nonce;
            end
            if (&seen_d) begin
              // found uses the best value including this final result.
              found_d = (best_hash_d < target_q);
              wcnt_d  = 5'd0;
              state_d = S_WRITE;
            end
          end
        end
      end

      S_WRITE: begin
        if (wcnt_q == LAST_CNT) begin
          state_d = S_IDLE;
        end else begin
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q + {11'd0, wcnt_q};
`ifdef BITCOIN_NONCE_SELECT_BEST_WORD_EN
          mem_data_d = wcnt_q[4] ? {27'd0, found_q, best_nonce_q} : buf_q[wcnt_q[3:0]];
`else
          mem_data_d = buf_q[wcnt_q[3:0]];
`endif
          wcnt_d     = wcnt_q + 5'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      target_q     <= '0;
      seen_q       <= '0;
      dup_q        <= 1'b0;
      best_hash_q  <= 32'hFFFF_FFFF;
      best_nonce_q <= 4'd0;
      found_q      <= 1'b0;
      wcnt_q       <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      target_q     <= target_d;
      seen_q       <= seen_d;
      dup_q        <= dup_d;
      best_hash_q  <= best_hash_d;
      best_nonce_q <= best_nonce_d;
      found_q      <= found_d;
      wcnt_q       <= wcnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  // Result buffer is data-only storage; its contents are irrelevant until a
  // full run has rewritten every entry, so it carries no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[in_nonce] <= in_hash;
    end
  end

  assign in_ready       = (state_q == S_COLLECT);
  assign done           = (state_q == S_IDLE);
  assign found          = found_q;
  assign best_nonce     = best_nonce_q;
  assign best_hash      = best_hash_q;
  assign dup_err        = dup_q;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_data_q;

endmodule

// File: doc/bitcoin_nonce_select.md
BITCOIN_NONCE_SELECT -- requirements
Module: bitcoin_nonce_select

Interface
REQ-001 Port clk, input, 1 -- sole clock; all state updates on its rising edge.
REQ-002 Port reset_n, input, 1 -- reset, asynchronous and active-low.
REQ-003 Port start, input, 1 -- begin a collection run; sampled only in IDLE.
REQ-004 Port output_addr, input, 16 -- base word address for result writes; latched on accepted start.
REQ-005 Port target, input, 32 -- difficulty threshold on final-hash word H0; latched on accepted start.
REQ-006 Port in_valid, input, 1 -- per-nonce result present from the phase-2/3 hash instances.
REQ-007 Port in_nonce, input, 4 -- nonce index 0..15 of the presented result.
REQ-008 Port in_hash, input, 32 -- final H0 word for in_nonce.
REQ-009 Port in_ready, output, 1 -- block accepts a result this cycle.
REQ-010 Port done, output, 1 -- high while in IDLE.
REQ-011 Port found, output, 1 -- best_hash < target for the last completed run.
REQ-012 Port best_nonce, output, 4 -- nonce of the smallest H0 in the last run.
REQ-013 Port best_hash, output, 32 -- smallest H0 in the last run.
REQ-014 Port dup_err, output, 1 -- sticky per run: a nonce was presented twice.
REQ-015 Port mem_clk, output, 1 -- equals clk.
REQ-016 Port mem_we, output, 1 -- memory write enable.
REQ-017 Port mem_addr, output, 16 -- memory word address.
REQ-018 Port mem_write_data, output, 32 -- memory write data.

Function
REQ-019 States: IDLE, COLLECT, WRITE; any unused encoding returns to IDLE next cycle.
REQ-020 IDLE with start=1 latches output_addr and target, clears the 16-bit seen mask and dup_err, sets best_hash=32'hFFFFFFFF and best_nonce=0, and moves to COLLECT; start outside IDLE is ignored.
REQ-021 in_ready is 1 only in COLLECT; a transfer occurs when in_valid and in_ready are both 1 on a rising edge.
REQ-022 On a transfer of a nonce not yet seen: store in_hash in buffer[in_nonce] and set seen[in_nonce].
REQ-023 Best update: on a new-nonce transfer, replace best if in_hash < best_hash, or if in_hash == best_hash and in_nonce < best_nonce (unsigned 32-bit compare).
REQ-024 A transfer whose nonce is already seen is dropped (buffer, mask and best unchanged) and sets dup_err.
REQ-025 Results may arrive in any nonce order, at most one per cycle; gaps with in_valid=0 are permitted.
REQ-026 The transfer that completes the mask (all 16 bits set) moves the block to WRITE on the next cycle; found is registered as (final best_hash < latched target) on that same edge.
REQ-027 WRITE issues one write per cycle for p=0..15: mem_we=1, mem_addr=output_addr+p, mem_write_data=buffer[p]; the address adds modulo 2^16.
REQ-028 After the last WRITE word: mem_we=0 and the block returns to IDLE; latency from the mask-completing transfer to done=1 is 18 cycles (17 with no best word; see REQ-033).
REQ-029 mem_we is 0 in every state other than WRITE; mem_addr and mem_write_data hold their last values outside WRITE.
REQ-030 found, best_nonce, best_hash and dup_err hold their values in IDLE until the next accepted start.

Reset
REQ-031 Async reset_n=0 forces IDLE, in_ready=0, done=1, found=0, best_nonce=0, best_hash=32'hFFFFFFFF, dup_err=0, mem_we=0, mem_addr=0, mem_write_data=0, and seen mask=0.
REQ-032 Reset mid-COLLECT or mid-WRITE abandons the run with no further writes; buffer contents are not reset and are don't-care.

Configuration
REQ-033 Macro BITCOIN_NONCE_SELECT_BEST_WORD_EN: when defined, WRITE appends a 17th word {27'b0, found, best_nonce} at output_addr+16, so the latency is 18 cycles; when undefined, exactly 16 words are written and the latency is 17 cycles.

Verification
REQ-034 Start with target=32'h10000000; present nonces 0..15 in order with hash=32'h80000000-nonce -> best_nonce=15, best_hash=32'h7FFFFFF1, found=0, writes to output_addr+0..15 match the inputs.
REQ-035 Present nonces in reverse order with nonce 9 hash=32'h00000042 and target=32'h00001000 -> found=1, best_nonce=9, best_hash=32'h00000042.
REQ-036 Present nonces 3 and 12 both with hash 32'h00000005, as the minimum, with 12 arriving first -> best_nonce=3.
REQ-037 Present nonce 7 twice with different hashes -> dup_err=1 and the first hash is retained; the run still completes after the remaining 15 nonces.
REQ-038 Start with output_addr=16'hFFF8 -> the writes wrap: word 8 goes to 16'h0000; with the macro defined, the best word goes to 16'h0008.
REQ-039 Assert reset_n=0 after 6 transfers, then restart -> no mem_we pulse occurs during or after the reset, and a full 16-result run completes normally.
